// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: memory-stage beat in, writeback beat out.
// slave = stage view, master = producer/consumer view.
interface mem_wb_stage_if #(
  parameter int N    = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_alu;
  logic [N-1:0]    in_mem;
  logic [N-1:0]    in_pc4;
  logic [N-1:0]    in_imm;
  logic [1:0]      in_wb_sel;
  logic [RA_W-1:0] in_rd;
  logic            in_we;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic [N-1:0]    c;
  logic [N-1:0]    d;
  logic            s0;
  logic            s1;
  logic [RA_W-1:0] rd;
  logic            we;

  modport slave (
    input  in_valid, in_alu, in_mem, in_pc4,
    input  in_imm, in_wb_sel, in_rd, in_we,
    output in_ready,
    output out_valid, a, b, c, d,
    output s0, s1, rd, we,
    input  out_ready
  );

  modport master (
    output in_valid, in_alu, in_mem, in_pc4,
    output in_imm, in_wb_sel, in_rd, in_we,
    input  in_ready,
    input  out_valid, a, b, c, d,
    input  s0, s1, rd, we,
    output out_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, valid/ready with stall and flush.
// Ports: clk, rst_n, flush, bus (mem_wb_stage_if.slave).
// MEM_WB_SKID_EN adds a skid entry and a registered in_ready.
module mem_wb_stage #(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  mem_wb_stage_if.slave  bus
);

  typedef struct packed {
    logic [N-1:0]    alu;
    logic [N-1:0]    mem;
    logic [N-1:0]    pc4;
    logic [N-1:0]    imm;
    logic [1:0]      sel;
    logic [RA_W-1:0] rd;
    logic            we;
  } beat_t;

`ifdef MEM_WB_SKID_EN
  typedef enum logic [1:0] {
    EMPTY, FULL, SKID
  } state_e;
`else
  typedef enum logic [1:0] {
    EMPTY, FULL
  } state_e;
`endif

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  in_beat;
  logic   xfer_in;
  logic   xfer_out;

  assign in_beat = '{
    alu: bus.in_alu,
    mem: bus.in_mem,
    pc4: bus.in_pc4,
    imm: bus.in_imm,
    sel: bus.in_wb_sel,
    rd:  bus.in_rd,
    we:  bus.in_we
  };

  assign bus.out_valid = (state_q != EMPTY);

`ifdef MEM_WB_SKID_EN
  beat_t skid_q, skid_d;
  // Decoded straight from the state flop: no out_ready path.
  assign bus.in_ready = (state_q != SKID);
`else
  assign bus.in_ready = !bus.out_valid
                      || bus.out_ready;
`endif

  assign xfer_in  = bus.in_valid && bus.in_ready;
  assign xfer_out = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef MEM_WB_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          state_d = FULL;
          main_d  = in_beat;
        end
      end
      FULL: begin
        if (xfer_out && xfer_in) begin
          main_d = in_beat;
        end else if (xfer_out) begin
          state_d = EMPTY;
`ifdef MEM_WB_SKID_EN
        end else if (xfer_in) begin
          state_d = SKID;
          skid_d  = in_beat;
`endif
        end
      end
`ifdef MEM_WB_SKID_EN
      SKID: begin
        if (xfer_out) begin
          state_d = FULL;
          main_d  = skid_q;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    // Flush drops only validity; payload flops hold.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
`ifdef MEM_WB_SKID_EN
      skid_d  = skid_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
`ifdef MEM_WB_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef MEM_WB_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  assign bus.a  = main_q.alu;
  assign bus.b  = main_q.mem;
  assign bus.c  = main_q.pc4;
  assign bus.d  = main_q.imm;
  assign bus.s0 = main_q.sel[0];
  assign bus.s1 = main_q.sel[1];
  assign bus.rd = main_q.rd;
  // x0 is hardwired zero: never request the write.
  assign bus.we = bus.out_valid
               && main_q.we
               && (main_q.rd != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: scoreboard of expected writeback beats.
// Honours MEM_WB_SKID_EN the same way as the design.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic        s0;
    logic        s1;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_chk;
  int   n_err;
  int   delivered;
  int   occ;
  int   d0;
  logic exp_rdy;
  exp_t e;
  exp_t hold_a;
  exp_t sbq[$];

  mem_wb_stage_if #(.N(32), .RA_W(5)) bus ();

  mem_wb_stage #(.N(32), .RA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string pfx,
                         input exp_t x);
    chk({pfx, "_a"}, 64'(bus.a), 64'(x.a));
    chk({pfx, "_b"}, 64'(bus.b), 64'(x.b));
    chk({pfx, "_c"}, 64'(bus.c), 64'(x.c));
    chk({pfx, "_d"}, 64'(bus.d), 64'(x.d));
    chk({pfx, "_s0"}, 64'(bus.s0), 64'(x.s0));
    chk({pfx, "_s1"}, 64'(bus.s1), 64'(x.s1));
    chk({pfx, "_rd"}, 64'(bus.rd), 64'(x.rd));
    chk({pfx, "_we"}, 64'(bus.we), 64'(x.we));
  endtask

  function automatic exp_t mk(input logic [31:0] al,
                              input logic [31:0] me,
                              input logic [31:0] pc,
                              input logic [31:0] im,
                              input logic [1:0]  sl,
                              input logic [4:0]  r,
                              input logic        w);
    exp_t x;
    x.a  = al;
    x.b  = me;
    x.c  = pc;
    x.d  = im;
    x.s0 = sl[0];
    x.s1 = sl[1];
    x.rd = r;
    x.we = w && (r != 5'd0);
    return x;
  endfunction

  // Scoreboard: occupancy model, pop on out-transfer, push on in-transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      occ = sbq.size();
`ifdef MEM_WB_SKID_EN
      exp_rdy = (occ < 2);
`else
      exp_rdy = (occ == 0) || bus.out_ready;
`endif
      chk("out_valid", 64'(bus.out_valid),
          64'(occ != 0));
      chk("in_ready", 64'(bus.in_ready),
          64'(exp_rdy));
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk_out("sb", e);
          delivered++;
        end
      end
      if (flush)
        sbq.delete();
      else if (bus.in_valid && exp_rdy)
        sbq.push_back(mk(bus.in_alu, bus.in_mem,
                         bus.in_pc4, bus.in_imm,
                         bus.in_wb_sel, bus.in_rd,
                         bus.in_we));
    end
  end

  task automatic set_beat(input logic [31:0] al,
                          input logic [31:0] me,
                          input logic [31:0] pc,
                          input logic [31:0] im,
                          input logic [1:0]  sl,
                          input logic [4:0]  r,
                          input logic        w);
    bus.in_alu    = al;
    bus.in_mem    = me;
    bus.in_pc4    = pc;
    bus.in_imm    = im;
    bus.in_wb_sel = sl;
    bus.in_rd     = r;
    bus.in_we     = w;
  endtask

  // Present a beat and return #1 after the edge that accepts it.
  task automatic send(input logic [31:0] al,
                      input logic [31:0] me,
                      input logic [31:0] pc,
                      input logic [31:0] im,
                      input logic [1:0]  sl,
                      input logic [4:0]  r,
                      input logic        w);
    int t;
    set_beat(al, me, pc, im, sl, r, w);
    bus.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50) chk("drain_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    delivered = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_beat(32'd0, 32'd0, 32'd0, 32'd0,
             2'd0, 5'd0, 1'b0);
    #12;
    chk_out("rst", mk(0, 0, 0, 0, 2'd0, 5'd0, 1'b0));
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Pass-through
    send(32'h10, 32'h20, 32'h1004, 32'hABCD0000,
         2'b01, 5'd5, 1'b1);
    bus.in_valid = 1'b0;
    chk("pt_b", 64'(bus.b), 64'h20);
    chk("pt_s0", 64'(bus.s0), 64'd1);
    chk("pt_s1", 64'(bus.s1), 64'd0);
    chk("pt_rd", 64'(bus.rd), 64'd5);
    chk("pt_we", 64'(bus.we), 64'd1);
    @(posedge clk);
    #1;

    // x0 write suppressed
    send(32'h1, 32'h2, 32'h3, 32'h4,
         2'b00, 5'd0, 1'b1);
    bus.in_valid = 1'b0;
    chk("x0_ov", 64'(bus.out_valid), 64'd1);
    chk("x0_we", 64'(bus.we), 64'd0);
    @(posedge clk);
    #1;

    // Stall with a held beat A, then B behind it
    bus.out_ready = 1'b0;
    hold_a = mk(32'hA1, 32'hA2, 32'hA3, 32'hA4,
                2'b10, 5'd10, 1'b1);
    d0 = delivered;
    send(32'hA1, 32'hA2, 32'hA3, 32'hA4,
         2'b10, 5'd10, 1'b1);
    set_beat(32'hB1, 32'hB2, 32'hB3, 32'hB4,
             2'b11, 5'd11, 1'b1);
`ifdef MEM_WB_SKID_EN
    @(posedge clk);
    #1;
    set_beat(32'hC1, 32'hC2, 32'hC3, 32'hC4,
             2'b00, 5'd12, 1'b1);
`endif
    repeat (3) begin
      @(negedge clk);
      chk("stall_rdy", 64'(bus.in_ready), 64'd0);
      chk_out("hold", hold_a);
    end
    @(posedge clk);
`ifdef MEM_WB_SKID_EN
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
`else
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
`endif
    drain();
    chk("stall_cnt", 64'(delivered - d0), 64'd2);

    // Flush kills the held beat and the incoming one
    bus.out_ready = 1'b0;
    send(32'hF1, 32'hF2, 32'hF3, 32'hF4,
         2'b00, 5'd20, 1'b1);
    set_beat(32'hE1, 32'hE2, 32'hE3, 32'hE4,
             2'b00, 5'd21, 1'b1);
    flush = 1'b1;
    d0 = delivered;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_ov", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("flush_cnt", 64'(delivered - d0), 64'd0);

    // Back-to-back with out_ready toggling
    d0 = delivered;
    fork
      begin
        repeat (40) begin
          @(posedge clk);
          #1 bus.out_ready = ~bus.out_ready;
        end
      end
      begin
        for (int i = 1; i <= 8; i++)
          send(32'(i) << 4, 32'(i) << 8,
               32'h1000 + 32'(i), 32'(i) << 16,
               2'(i), 5'(i), 1'b1);
        bus.in_valid = 1'b0;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("b2b_cnt", 64'(delivered - d0), 64'd8);

    // Asynchronous reset with a held beat
    bus.out_ready = 1'b0;
    send(32'h71, 32'h72, 32'h73, 32'h74,
         2'b11, 5'd7, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(bus.out_valid), 64'd0);
    chk_out("arst", mk(0, 0, 0, 0, 2'd0, 5'd0, 1'b0));
    chk("arst_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("arel_rdy", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
